// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the MEM-stage load/store unit.
//   lsu_op_t     : 3-bit operation code presented on req_op
//   lsu_state_t  : sequencer states
//   misaligned   : alignment check for an op at a given byte offset
//   is_store     : true for SW/SH/SB
//   lane_extract : select a byte/halfword lane from a word and sign/zero extend
//   lane_merge   : replace a byte/halfword lane of a word with store data
// Byte lanes are little-endian: lane n = word[8n+7:8n].
// -----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LH  = 3'b001,
      OP_LHU = 3'b010,
      OP_LB  = 3'b011,
      OP_LBU = 3'b100,
      OP_SW  = 3'b101,
      OP_SH  = 3'b110,
      OP_SB  = 3'b111
   } lsu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   function automatic logic is_store(lsu_op_t op);
      logic r;
      r = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
      return r;
   endfunction

   // Halfwords need an even address, words need addr[1:0] == 0; bytes never fault.
   function automatic logic misaligned(lsu_op_t op, logic [1:0] addr);
      logic r;
      case (op)
         OP_LW, OP_SW:         r = (addr != 2'b00);
         OP_LH, OP_LHU, OP_SH: r = addr[0];
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_extract(logic [31:0] word, logic [1:0] addr, lsu_op_t op);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (addr)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = addr[1] ? word[31:16] : word[15:0];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'd0, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] lane_merge(logic [31:0] word, logic [31:0] wdata,
                                              logic [1:0] addr, lsu_op_t op);
      logic [31:0] r;
      r = word;
      case (op)
         OP_SB: begin
            case (addr)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         OP_SH: begin
            if (addr[1]) r[31:16] = wdata[15:0];
            else         r[15:0]  = wdata[15:0];
         end
         OP_SW:   r = wdata;
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane handling for the load/store unit.
//   op         in  operation of the access in flight
//   lane       in  byte offset addr[1:0]
//   rd_word    in  word returned by memory (load path)
//   merge_base in  previously read word (read-modify-write path)
//   wdata      in  store data
//   load_data  out extended load result
//   merge_data out word to write back (full word for SW)
// -----------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
(
   input  lsu_op_t     op,
   input  logic [1:0]  lane,
   input  logic [31:0] rd_word,
   input  logic [31:0] merge_base,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   assign load_data  = lane_extract(rd_word, lane, op);
   assign merge_data = lane_merge(merge_base, wdata, lane, op);

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// MEM-stage sequencer between the pipeline and a word-only data memory.
// Sub-word loads are extended, sub-word stores are read-modify-write, and
// misaligned / out-of-range requests complete with err without touching memory.
// One request is in flight at a time; busy stalls the pipeline.
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (accept = valid & ready)
//   req_op/req_addr/req_wdata  operation, byte address, store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion, load data, error
//   busy                       sequencer not idle
//   mem_read/mem_write         memory strobes (never both high)
//   mem_addr/mem_wdata         word address and write word
//   mem_rdata                  combinational read data
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS_LOG2 = 8,
   parameter bit RANGE_CHECK    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state_reg, state_next;
   lsu_op_t     op_reg;
   logic [29:0] word_addr_reg;
   logic [1:0]  lane_reg;
   logic [31:0] wdata_reg;
   logic        err_reg;
   logic [31:0] rbuf_reg;
   logic [31:0] resp_rdata_reg;

   lsu_op_t     req_op_e;
   logic        range_err;
   logic        acc_err;
   logic        accept;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   assign req_op_e = lsu_op_t'(req_op);

   generate
      if (RANGE_CHECK && (MEM_WORDS_LOG2 < 30)) begin : g_range
         assign range_err = |req_addr[31:MEM_WORDS_LOG2+2];
      end else begin : g_no_range
         assign range_err = 1'b0;
      end
   endgenerate

   assign acc_err = range_err | misaligned(req_op_e, req_addr[1:0]);
   assign accept  = req_valid & req_ready;

   lsu_lane_align u_align (
      .op         (op_reg),
      .lane       (lane_reg),
      .rd_word    (mem_rdata),
      .merge_base (rbuf_reg),
      .wdata      (wdata_reg),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   // Next state and strobes. Strobes are masked by reset so an aborted
   // access never writes in the reset cycle.
   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = 32'd0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      busy       = (state_reg != ST_IDLE);
      case (state_reg)
         ST_IDLE: begin
            req_ready = ~reset;
            if (accept) begin
               if (acc_err)                 state_next = ST_RESP;
               else if (req_op_e == OP_SW)  state_next = ST_WRITE;
               else                         state_next = ST_READ;
            end
         end
         ST_READ: begin
            mem_read   = ~reset;
            state_next = is_store(op_reg) ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            mem_write  = ~reset;
            mem_wdata  = reset ? 32'd0 : merge_data;
            state_next = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = ~reset;
            resp_err   = ~reset & err_reg;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         op_reg         <= OP_LW;
         word_addr_reg  <= 30'd0;
         lane_reg       <= 2'd0;
         wdata_reg      <= 32'd0;
         err_reg        <= 1'b0;
         rbuf_reg       <= 32'd0;
         resp_rdata_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg        <= req_op_e;
            word_addr_reg <= req_addr[31:2];
            lane_reg      <= req_addr[1:0];
            wdata_reg     <= req_wdata;
            err_reg       <= acc_err;
            // An error goes straight to RESP, so its zero result lands now.
            if (acc_err) resp_rdata_reg <= 32'd0;
         end
         // resp_rdata only changes on the edge that enters RESP, so the
         // previous result stays visible until the next completion.
         if (state_reg == ST_READ) begin
            rbuf_reg <= mem_rdata;
            if (!is_store(op_reg)) resp_rdata_reg <= load_data;
         end
         if (state_reg == ST_WRITE) resp_rdata_reg <= 32'd0;
      end
   end

   assign mem_addr   = {word_addr_reg, 2'b00};
   assign resp_rdata = resp_rdata_reg;

endmodule
